duty_level_ctrl: RTL and testbench
==================================

# duty_level_ctrl

Pushbutton-driven duty-level controller producing the 4-bit `duty_multiplier` consumed by the PWM generator stage. Two raw active-low pushbuttons (up/down) are synchronised, debounced and edge-detected, optionally auto-repeated while held, and used to step a saturating level register between 0 and MAX_LEVEL. Sits directly between the board buttons and the PWM stage; its output connects straight to the PWM duty input.

## Interface
- DEBOUNCE_CYCLES, 50000: consecutive cycles of disagreement required before a debounced button state flips; ≥1.
- MAX_LEVEL, 10: upper saturation bound of the level; ≤15.
- RESET_LEVEL, 0: level loaded on reset; ≤MAX_LEVEL.
- REPEAT_DELAY, 0: cycles after a press step before the first auto-repeat step; 0 disables auto-repeat.
- REPEAT_PERIOD, 12500000: cycles between subsequent auto-repeat steps; ≥1.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- btn_up_n  in  1  raw up button, active-low, asynchronous to clk, may bounce.
- btn_dn_n  in  1  raw down button, same properties.
- duty_multiplier  out  4  current level, 0..MAX_LEVEL, registered.
- at_max  out  1  registered, high when duty_multiplier == MAX_LEVEL.
- at_min  out  1  registered, high when duty_multiplier == 0.
- level_changed  out  1  registered one-cycle pulse, high in the cycle after duty_multiplier took a new value.

## Operation
- Per button: 2-flop synchroniser → debouncer → rising-press detector → auto-repeat generator → step pulse.
- Debouncer: counter increments on each edge where synchronised value ≠ stable value; any edge of agreement clears it; the stable value flips at the edge where the count reaches DEBOUNCE_CYCLES, and the counter clears. Counter width = clog2(DEBOUNCE_CYCLES+1).
- Press step: one-cycle pulse on a stable released→pressed transition. Release produces no step.
- Auto-repeat (REPEAT_DELAY > 0): hold counter clears on press and counts while stable is pressed; first repeat step REPEAT_DELAY cycles after the press step, then every REPEAT_PERIOD cycles; release clears the counter immediately, with no further steps.
- Level update on each edge: up step only → +1 unless at MAX_LEVEL; down step only → −1 unless 0; both steps in the same cycle → no change; none → hold. No wrap-around in either direction.
- level_changed is asserted only when the value actually changes; a saturated step produces no pulse.
- at_max/at_min are derived from the next-level value and registered together with duty_multiplier, so they are always consistent with it.

## Timing
- Reset (async assert, sync-released use): duty_multiplier=RESET_LEVEL, at_max/at_min per RESET_LEVEL, level_changed=0, synchronisers and stable states = released (1), all counters 0.
- Button held across reset release: seen as a new press once debounced (one step).
- Press latency: raw low first sampled at edge E → sync low after E+1 → stable flips at edge E+1+DEBOUNCE_CYCLES → duty_multiplier updates at edge E+2+DEBOUNCE_CYCLES → level_changed high for the following cycle.
- Bounce shorter than DEBOUNCE_CYCLES consecutive cycles → no stable change and no step.
- Reset asserted mid-debounce or mid-repeat: all progress discarded immediately.
- Maximum step rate: one step per cycle per button; the level register accepts a step every cycle.

## Test plan
- DEBOUNCE_CYCLES=4, RESET_LEVEL=0: hold btn_up_n low from edge 1 → duty_multiplier 0→1 at edge 7, level_changed high one cycle, at_min 1→0.
- Bounce btn_up_n low 3 cycles, high 1, repeated 5 times, then release → duty_multiplier stays 0, level_changed never asserts.
- 12 clean up presses from 0 with MAX_LEVEL=10 → level reaches 10, at_max=1; presses 11–12 cause no change and no level_changed pulse. Then 11 down presses → 0, at_min=1, no underflow to 15.
- Both buttons pressed on the same cycle at level 5 → level stays 5 and no pulse; release up only, press up again → 6.
- REPEAT_DELAY=20, REPEAT_PERIOD=8, DEBOUNCE_CYCLES=4: hold up from level 0 for 60 cycles after stable → steps at press, +20, +28, +36, +44, +52 (level 6); release → no further steps.
- Hold up, assert rst mid-repeat at level 3 → immediately duty_multiplier=RESET_LEVEL; deassert with button still held → exactly one step after debounce latency.

Source files
------------

// File: rtl/duty_level_ctrl.sv
// Pushbutton duty-level controller: per-button sync/debounce/press/auto-repeat
// chains feed a saturating 0..MAX_LEVEL level register for the PWM stage.

module duty_level_btn #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 12500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic step
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = (RP_MAX < 1) ? 1 : $clog2(RP_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_PERIOD
  } rpt_state_t;

  logic            sync_meta;
  logic            sync_q;
  logic            stable;
  logic            stable_d;
  logic [DB_W-1:0] db_cnt;
  logic            press;
  logic            fire;
  rpt_state_t      state;
  rpt_state_t      state_nxt;
  logic [RP_W-1:0] rep_cnt;
  logic [RP_W-1:0] rep_cnt_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta <= 1'b1;
      sync_q    <= 1'b1;
    end else begin
      sync_meta <= btn_n;
      sync_q    <= sync_meta;
    end
  end

  // Stable value flips only after DEBOUNCE_CYCLES consecutive disagreeing edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable   <= 1'b1;
      stable_d <= 1'b1;
      db_cnt   <= '0;
    end else begin
      stable_d <= stable;
      if (sync_q != stable) begin
        if (db_cnt == DB_LAST) begin
          stable <= sync_q;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign press = stable_d & ~stable;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RPT_IDLE;
      rep_cnt <= '0;
    end else begin
      state   <= state_nxt;
      rep_cnt <= rep_cnt_nxt;
    end
  end

  // Repeat steps are gated on the stable pressed state, so a release kills them at once.
  always_comb begin
    state_nxt   = state;
    rep_cnt_nxt = rep_cnt;
    fire        = 1'b0;
    if (REPEAT_DELAY == 0 || stable) begin
      state_nxt   = RPT_IDLE;
      rep_cnt_nxt = '0;
    end else if (press) begin
      state_nxt   = RPT_DELAY;
      rep_cnt_nxt = '0;
    end else begin
      case (state)
        RPT_DELAY: begin
          if (rep_cnt == DELAY_LAST) begin
            fire        = 1'b1;
            state_nxt   = RPT_PERIOD;
            rep_cnt_nxt = '0;
          end else begin
            rep_cnt_nxt = rep_cnt + 1'b1;
          end
        end
        RPT_PERIOD: begin
          if (rep_cnt == PERIOD_LAST) begin
            fire        = 1'b1;
            rep_cnt_nxt = '0;
          end else begin
            rep_cnt_nxt = rep_cnt + 1'b1;
          end
        end
        default: begin
          state_nxt   = RPT_IDLE;
          rep_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign step = press | fire;

endmodule

module duty_level_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int MAX_LEVEL       = 10,
  parameter int RESET_LEVEL     = 0,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up_n,
  input  logic       btn_dn_n,
  output logic [3:0] duty_multiplier,
  output logic       at_max,
  output logic       at_min,
  output logic       level_changed
);

  localparam logic [3:0] MAX_L = 4'(MAX_LEVEL);
  localparam logic [3:0] RST_L = 4'(RESET_LEVEL);

  logic       step_up;
  logic       step_dn;
  logic [3:0] level_nxt;

  duty_level_btn #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_btn_up (
    .clk  (clk),
    .rst  (rst),
    .btn_n(btn_up_n),
    .step (step_up)
  );

  duty_level_btn #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_btn_dn (
    .clk  (clk),
    .rst  (rst),
    .btn_n(btn_dn_n),
    .step (step_dn)
  );

  // Simultaneous up and down steps cancel; saturation at both ends, never wraps.
  always_comb begin
    level_nxt = duty_multiplier;
    if (step_up && !step_dn && duty_multiplier != MAX_L) begin
      level_nxt = duty_multiplier + 4'd1;
    end else if (step_dn && !step_up && duty_multiplier != 4'd0) begin
      level_nxt = duty_multiplier - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty_multiplier <= RST_L;
      at_max          <= (RST_L == MAX_L);
      at_min          <= (RST_L == 4'd0);
      level_changed   <= 1'b0;
    end else begin
      duty_multiplier <= level_nxt;
      at_max          <= (level_nxt == MAX_L);
      at_min          <= (level_nxt == 4'd0);
      level_changed   <= (level_nxt != duty_multiplier);
    end
  end

endmodule

// File: tb/tb_duty_level_ctrl.sv
// Directed bench for duty_level_ctrl with short debounce and auto-repeat enabled.

module tb_duty_level_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_up_n;
  logic       btn_dn_n;
  logic [3:0] duty_multiplier;
  logic       at_max;
  logic       at_min;
  logic       level_changed;

  int errors;
  int checks;
  int lc_count;
  int lc_snap;
  int lc_snap2;

  duty_level_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .MAX_LEVEL      (10),
    .RESET_LEVEL    (0),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_up_n       (btn_up_n),
    .btn_dn_n       (btn_dn_n),
    .duty_multiplier(duty_multiplier),
    .at_max         (at_max),
    .at_min         (at_min),
    .level_changed  (level_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (level_changed === 1'b1) lc_count++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One clean press: step lands 7 ticks after the drive, released well before repeat starts.
  task automatic press(input bit up, input bit dn);
    if (up) btn_up_n = 1'b0;
    if (dn) btn_dn_n = 1'b0;
    tick(8);
    btn_up_n = 1'b1;
    btn_dn_n = 1'b1;
    tick(8);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    lc_count = 0;
    rst      = 1'b0;
    btn_up_n = 1'b1;
    btn_dn_n = 1'b1;
    tick(3);
    check("reset_level", duty_multiplier, 0);
    check("reset_at_min", at_min, 1);
    check("reset_at_max", at_max, 0);
    check("reset_lc", level_changed, 0);
    rst = 1'b1;
    tick(2);

    $display("[TB] single press latency");
    btn_up_n = 1'b0;
    tick(6);
    check("press_before_edge7", duty_multiplier, 0);
    check("press_at_min_before", at_min, 1);
    tick(1);
    check("press_level", duty_multiplier, 1);
    check("press_lc_high", level_changed, 1);
    check("press_at_min_after", at_min, 0);
    tick(1);
    check("press_lc_one_cycle", level_changed, 0);
    btn_up_n = 1'b1;
    tick(8);
    check("release_no_step", duty_multiplier, 1);

    press(1'b0, 1'b1);
    check("down_to_zero", duty_multiplier, 0);
    check("down_at_min", at_min, 1);

    $display("[TB] bounce rejection");
    lc_snap = lc_count;
    for (int i = 0; i < 5; i++) begin
      btn_up_n = 1'b0;
      tick(3);
      btn_up_n = 1'b1;
      tick(1);
    end
    tick(10);
    check("bounce_level", duty_multiplier, 0);
    check("bounce_no_pulse", lc_count - lc_snap, 0);

    $display("[TB] saturate up then down");
    lc_snap  = lc_count;
    lc_snap2 = 0;
    for (int i = 1; i <= 12; i++) begin
      press(1'b1, 1'b0);
      check($sformatf("up_press_%0d", i), duty_multiplier, (i > 10) ? 10 : i);
      if (i == 10) lc_snap2 = lc_count;
    end
    check("up_at_max", at_max, 1);
    check("up_pulses", lc_count - lc_snap, 10);
    check("up_saturated_no_pulse", lc_count - lc_snap2, 0);
    lc_snap = lc_count;
    for (int i = 1; i <= 11; i++) begin
      press(1'b0, 1'b1);
      check($sformatf("dn_press_%0d", i), duty_multiplier, (i > 10) ? 0 : 10 - i);
    end
    check("dn_at_min", at_min, 1);
    check("dn_at_max", at_max, 0);
    check("dn_pulses", lc_count - lc_snap, 10);

    $display("[TB] simultaneous presses");
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
    check("level_five", duty_multiplier, 5);
    lc_snap  = lc_count;
    btn_up_n = 1'b0;
    btn_dn_n = 1'b0;
    tick(6);
    btn_up_n = 1'b1;
    tick(6);
    check("both_no_change", duty_multiplier, 5);
    check("both_no_pulse", lc_count - lc_snap, 0);
    btn_up_n = 1'b0;
    tick(7);
    check("up_while_dn_held", duty_multiplier, 6);
    btn_up_n = 1'b1;
    btn_dn_n = 1'b1;
    tick(12);
    check("after_both_release", duty_multiplier, 6);

    $display("[TB] auto-repeat");
    rst = 1'b0;
    #1;
    check("async_reset_level", duty_multiplier, 0);
    tick(2);
    rst = 1'b1;
    tick(2);
    lc_snap  = lc_count;
    btn_up_n = 1'b0;
    tick(7);
    check("rpt_press_step", duty_multiplier, 1);
    tick(19);
    check("rpt_before_first", duty_multiplier, 1);
    tick(1);
    check("rpt_first", duty_multiplier, 2);
    tick(7);
    check("rpt_before_second", duty_multiplier, 2);
    tick(1);
    check("rpt_second", duty_multiplier, 3);
    tick(8);
    check("rpt_third", duty_multiplier, 4);
    tick(8);
    check("rpt_fourth", duty_multiplier, 5);
    tick(8);
    check("rpt_fifth", duty_multiplier, 6);
    btn_up_n = 1'b1;
    tick(30);
    check("rpt_release_hold", duty_multiplier, 6);
    check("rpt_pulses", lc_count - lc_snap, 6);

    $display("[TB] reset during repeat");
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
    btn_up_n = 1'b0;
    tick(35);
    check("mid_rpt_level", duty_multiplier, 3);
    tick(1);
    rst = 1'b0;
    #1;
    check("mid_rpt_reset_level", duty_multiplier, 0);
    check("mid_rpt_reset_at_min", at_min, 1);
    check("mid_rpt_reset_lc", level_changed, 0);
    tick(3);
    rst = 1'b1;
    lc_snap = lc_count;
    tick(6);
    check("held_before_step", duty_multiplier, 0);
    tick(1);
    check("held_one_step", duty_multiplier, 1);
    check("held_lc", level_changed, 1);
    btn_up_n = 1'b1;
    tick(30);
    check("held_exactly_one", duty_multiplier, 1);
    check("held_pulses", lc_count - lc_snap, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
